// File: rtl/ibex_pkg.sv
// Shared FPU issue/writeback types: operation encoding, fclass codes and result entry layout.
package ibex_pkg;

    localparam int unsigned FPU_DEPTH = 2;
    localparam int unsigned FPU_RD_W  = 5;
    localparam int unsigned FPU_XLEN  = 32;

    typedef enum logic [2:0] {
        FP_ADD    = 3'd0,
        FP_SUB    = 3'd1,
        FP_MUL    = 3'd2,
        FP_MINMAX = 3'd3,
        FP_SGNJ   = 3'd4,
        FP_CMP    = 3'd5,
        FP_CLASS  = 3'd6,
        FP_CVT    = 3'd7
    } fp_alu_op_e;

    // One-hot fclass result, bit order as returned in the low bits of rd.
    typedef enum logic [9:0] {
        FCLASS_NEG_INF  = 10'b00_0000_0001,
        FCLASS_NEG_NORM = 10'b00_0000_0010,
        FCLASS_NEG_SUB  = 10'b00_0000_0100,
        FCLASS_NEG_ZERO = 10'b00_0000_1000,
        FCLASS_POS_ZERO = 10'b00_0001_0000,
        FCLASS_POS_SUB  = 10'b00_0010_0000,
        FCLASS_POS_NORM = 10'b00_0100_0000,
        FCLASS_POS_INF  = 10'b00_1000_0000,
        FCLASS_SNAN     = 10'b01_0000_0000,
        FCLASS_QNAN     = 10'b10_0000_0000
    } Classif_e;

    // Result FIFO entry: result in the upper bits, destination index in the lower bits.
    typedef struct packed {
        logic [FPU_XLEN-1:0] result;
        logic [FPU_RD_W-1:0] rd;
    } fpu_res_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with push/pop/flush and occupancy count; DEPTH must be a power of two.
module fpu_result_fifo
    import ibex_pkg::*;
#(
    parameter  int unsigned DEPTH = FPU_DEPTH,
    parameter  int unsigned W     = $bits(fpu_res_t),
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
    assign w_pop  = pop_i & (r_count != '0);
    assign w_push = push_i & ((r_count != CNT_W'(DEPTH)) | w_pop);

    // Pointer and count update; flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage; cleared on reset so the head reads as zero until the first write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/fpu_issue_wb.sv
// Issue/writeback stage around the combinational bf16 FPU: execute register, result FIFO, WAW scoreboard.
module fpu_issue_wb
    import ibex_pkg::*;
#(
    parameter  int unsigned DEPTH = FPU_DEPTH,
    parameter  int unsigned RD_W  = FPU_RD_W,
    localparam int unsigned NREG  = 32'(1) << RD_W,
    localparam int unsigned ENT_W = 32 + RD_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  fp_alu_op_e      req_op_i,
    input  logic [31:0]     req_a_i,
    input  logic [31:0]     req_b_i,
    input  logic [1:0]      req_mode_i,
    input  logic [RD_W-1:0] req_rd_i,

    output fp_alu_op_e      fpu_operator_o,
    output logic [31:0]     fpu_operand_a_o,
    output logic [31:0]     fpu_operand_b_o,
    output logic [1:0]      fpu_mode_o,
    input  logic [31:0]     fpu_result_i,

    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_result_o,
    output logic [RD_W-1:0] wb_rd_o,

    output logic [NREG-1:0] pend_mask_o,
    output logic            busy_o
);

    logic             r_e_valid;
    fp_alu_op_e       r_e_op;
    logic [31:0]      r_e_a;
    logic [31:0]      r_e_b;
    logic [1:0]       r_e_mode;
    logic [RD_W-1:0]  r_e_rd;
    logic [NREG-1:0]  r_pend_mask;

    logic [NREG-1:0]  w_pend_nxt;
    logic [CNT_W-1:0] w_count;
    logic [ENT_W-1:0] w_push_data;
    logic [ENT_W-1:0] w_head;
    logic             w_fifo_nonempty;
    logic             w_fifo_room;
    logic             w_wb_pop;
    logic             w_e_adv;
    logic             w_accept;

    assign w_fifo_nonempty = (w_count != '0);
    assign w_fifo_room     = (w_count < CNT_W'(DEPTH));
    assign w_wb_pop        = w_fifo_nonempty & wb_ready_i;
    assign w_e_adv         = r_e_valid & (w_fifo_room | w_wb_pop);

    // WAW stall on any pending rd, no bypass; E must be empty or moving on this cycle.
    assign req_ready_o = ~flush_i & ~r_pend_mask[req_rd_i] & (~r_e_valid | w_e_adv);
    assign w_accept    = req_valid_i & req_ready_o;

    // Execute register: loads on accept, clears when its op moves into the FIFO, flush kills it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_e_valid <= 1'b0;
            r_e_op    <= FP_ADD;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_e_mode  <= '0;
            r_e_rd    <= '0;
        end else if (flush_i) begin
            r_e_valid <= 1'b0;
            r_e_op    <= FP_ADD;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_e_mode  <= '0;
            r_e_rd    <= '0;
        end else if (w_accept) begin
            r_e_valid <= 1'b1;
            r_e_op    <= req_op_i;
            r_e_a     <= req_a_i;
            r_e_b     <= req_b_i;
            r_e_mode  <= req_mode_i;
            r_e_rd    <= req_rd_i;
        end else if (w_e_adv) begin
            r_e_valid <= 1'b0;
            r_e_op    <= FP_ADD;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_e_mode  <= '0;
            r_e_rd    <= '0;
        end
    end

    // Scoreboard next state: retire the popped rd, mark the accepted rd (x0 is never tracked).
    always_comb begin
        w_pend_nxt = r_pend_mask;
        if (w_wb_pop) begin
            w_pend_nxt[wb_rd_o] = 1'b0;
        end
        if (w_accept && (req_rd_i != '0)) begin
            w_pend_nxt[req_rd_i] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_mask <= '0;
        end else if (flush_i) begin
            r_pend_mask <= '0;
        end else begin
            r_pend_mask <= w_pend_nxt;
        end
    end

    assign w_push_data = {fpu_result_i, r_e_rd};

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_e_adv),
        .data_i  (w_push_data),
        .pop_i   (w_wb_pop),
        .data_o  (w_head),
        .count_o (w_count)
    );

    assign fpu_operator_o  = r_e_op;
    assign fpu_operand_a_o = r_e_a;
    assign fpu_operand_b_o = r_e_b;
    assign fpu_mode_o      = r_e_mode;

    assign wb_valid_o  = w_fifo_nonempty;
    assign wb_result_o = w_head[ENT_W-1 -: 32];
    assign wb_rd_o     = w_head[RD_W-1:0];
    assign pend_mask_o = r_pend_mask;
    assign busy_o      = r_e_valid | w_fifo_nonempty;

    // Head must hold while writeback stalls it.
    a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_valid_o && !wb_ready_i && !flush_i) |=> (wb_valid_o && $stable(wb_result_o) && $stable(wb_rd_o)));

    // The WAW stall rules out setting and clearing the same scoreboard bit together.
    a_no_set_clr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_accept && w_wb_pop && (req_rd_i == wb_rd_o) && (req_rd_i != '0)));

endmodule

// File: tb/tb_fpu_issue_wb.sv
// Bench for fpu_issue_wb: directed scenarios plus random traffic against a queue-based reference model.
module tb_fpu_issue_wb;
    import ibex_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned NREG  = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            req_valid_i;
    logic            req_ready_o;
    fp_alu_op_e      req_op_i;
    logic [31:0]     req_a_i;
    logic [31:0]     req_b_i;
    logic [1:0]      req_mode_i;
    logic [RD_W-1:0] req_rd_i;
    fp_alu_op_e      fpu_operator_o;
    logic [31:0]     fpu_operand_a_o;
    logic [31:0]     fpu_operand_b_o;
    logic [1:0]      fpu_mode_o;
    logic [31:0]     fpu_result_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [31:0]     wb_result_o;
    logic [RD_W-1:0] wb_rd_o;
    logic [NREG-1:0] pend_mask_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    fpu_issue_wb #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_mode_i      (req_mode_i),
        .req_rd_i        (req_rd_i),
        .fpu_operator_o  (fpu_operator_o),
        .fpu_operand_a_o (fpu_operand_a_o),
        .fpu_operand_b_o (fpu_operand_b_o),
        .fpu_mode_o      (fpu_mode_o),
        .fpu_result_i    (fpu_result_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_result_o     (wb_result_o),
        .wb_rd_o         (wb_rd_o),
        .pend_mask_o     (pend_mask_o),
        .busy_o          (busy_o)
    );

    // ---------------- behavioural bf16 FPU stand-in ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r * 0.5;
        return r;
    endfunction

    function automatic real bf_to_real(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real r;
        if (e == 0) return 0.0;
        r = (1.0 + real'(int'(x[22:16])) / 128.0) * pow2(e - 127);
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real_to_bf(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0)   return {d[63], 31'h0};
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], e[7:0], d[51:45], 16'h0};
    endfunction

    function automatic logic [31:0] class_of(input logic [31:0] x);
        logic [9:0] c;
        if (x[30:23] == 8'hFF)      c = (x[22:16] == 7'd0) ? (x[31] ? 10'd1 : 10'd128) : (x[22] ? 10'd512 : 10'd256);
        else if (x[30:23] == 8'h00) c = (x[22:16] == 7'd0) ? (x[31] ? 10'd8 : 10'd16) : (x[31] ? 10'd4 : 10'd32);
        else                        c = x[31] ? 10'd2 : 10'd64;
        return {22'h0, c};
    endfunction

    function automatic logic [31:0] fpu_model(input fp_alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] mode);
        case (op)
            FP_ADD:   return real_to_bf(bf_to_real(a) + bf_to_real(b));
            FP_SUB:   return real_to_bf(bf_to_real(a) - bf_to_real(b));
            FP_MUL:   return real_to_bf(bf_to_real(a) * bf_to_real(b));
            FP_CLASS: return class_of(a);
            FP_CVT: begin
                if (mode[1]) return real_to_bf(mode[0] ? real'($signed(a)) : real'(longint'({32'h0, a})));
                return a ^ 32'h5A5A_0000;
            end
            default:  return 32'h0;
        endcase
    endfunction

    always_comb fpu_result_i = fpu_model(fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o);

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: ordered list of outstanding ops ----------------
    typedef struct {
        logic [31:0]     res;
        logic [RD_W-1:0] rd;
        bit              in_fifo;
    } ent_t;

    ent_t            mq[$];
    int              q_pop_cyc[$];
    logic [31:0]     q_pop_res[$];
    logic [RD_W-1:0] q_pop_rd[$];

    function automatic int m_fifo_n();
        int n = 0;
        foreach (mq[i]) if (mq[i].in_fifo) n++;
        return n;
    endfunction

    function automatic logic [NREG-1:0] m_mask();
        logic [NREG-1:0] m = '0;
        foreach (mq[i]) if (mq[i].rd != '0) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic clear_log();
        q_pop_cyc.delete();
        q_pop_res.delete();
        q_pop_rd.delete();
    endtask

    // One clock cycle starting at a falling edge: drive, check against the model, clock, update the model.
    task automatic cycle(input bit v, input fp_alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] mode, input logic [RD_W-1:0] rd, input bit wr, input bit fl,
                         output bit acc_obs);
        bit              exp_valid, exp_ready, pop;
        int              fifo_n;
        logic [NREG-1:0] mask;
        ent_t            e;
        req_valid_i = v;  req_op_i = op;  req_a_i = a;  req_b_i = b;
        req_mode_i = mode;  req_rd_i = rd;  wb_ready_i = wr;  flush_i = fl;
        #1;
        exp_valid = (m_fifo_n() > 0);
        mask      = m_mask();
        chk("wb_valid", 64'(wb_valid_o), 64'(exp_valid));
        chk("busy", 64'(busy_o), 64'(mq.size() > 0));
        chk("pend_mask", 64'(pend_mask_o), 64'(mask));
        if (exp_valid) begin
            chk("wb_result", 64'(wb_result_o), 64'(mq[0].res));
            chk("wb_rd", 64'(wb_rd_o), 64'(mq[0].rd));
        end
        pop       = exp_valid && wr;
        exp_ready = !fl && !mask[rd] && ((mq.size() <= int'(DEPTH)) || pop);
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        acc_obs = v && req_ready_o;
        if (wb_valid_o && wr) begin
            q_pop_cyc.push_back(cyc);
            q_pop_res.push_back(wb_result_o);
            q_pop_rd.push_back(wb_rd_o);
        end
        @(posedge clk_i);
        fifo_n = m_fifo_n();
        if (pop) void'(mq.pop_front());
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && !mq[mq.size()-1].in_fifo && (fifo_n < int'(DEPTH) || pop))
                mq[mq.size()-1].in_fifo = 1'b1;
            if (v && exp_ready) begin
                e.res = fpu_model(op, a, b, mode);
                e.rd = rd;
                e.in_fifo = 1'b0;
                mq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit wr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, FP_ADD, 32'h0, 32'h0, 2'b00, '0, wr, 1'b0, acc);
    endtask

    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int c0;
        rst_ni = 1'b0;  flush_i = 1'b0;  req_valid_i = 1'b0;  req_op_i = FP_ADD;
        req_a_i = '0;  req_b_i = '0;  req_mode_i = '0;  req_rd_i = '0;  wb_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_pend", 64'(pend_mask_o), 64'd0);
        chk("reset_wb_result", 64'(wb_result_o), 64'd0);
        chk("reset_fpu_a", 64'(fpu_operand_a_o), 64'd0);
        rst_ni = 1'b1;

        // Basic ADD 1.0 + 2.0 -> rd3
        clear_log();
        c0 = cyc;
        cycle(1'b1, FP_ADD, ONE, TWO, 2'b00, 5'd3, 1'b1, 1'b0, acc);
        chk("add_accept", 64'(acc), 64'd1);
        chk("add_pend3", 64'(pend_mask_o[3]), 64'd1);
        chk("add_not_yet_valid", 64'(wb_valid_o), 64'd0);
        idle(3, 1'b1);
        chk("add_pops", 64'(q_pop_res.size()), 64'd1);
        chk("add_result", 64'(q_pop_res[0]), 64'h4040_0000);
        chk("add_rd", 64'(q_pop_rd[0]), 64'd3);
        chk("add_latency", 64'(q_pop_cyc[0] - c0), 64'd2);
        chk("add_pend3_clear", 64'(pend_mask_o[3]), 64'd0);

        // Back-to-back MUL, SUB, CLASS
        clear_log();
        cycle(1'b1, FP_MUL, TWO, 32'h4040_0000, 2'b00, 5'd4, 1'b1, 1'b0, acc);
        chk("b2b_acc0", 64'(acc), 64'd1);
        cycle(1'b1, FP_SUB, ONE, TWO, 2'b00, 5'd5, 1'b1, 1'b0, acc);
        chk("b2b_acc1", 64'(acc), 64'd1);
        cycle(1'b1, FP_CLASS, 32'hFF80_0000, 32'h0, 2'b00, 5'd6, 1'b1, 1'b0, acc);
        chk("b2b_acc2", 64'(acc), 64'd1);
        idle(4, 1'b1);
        chk("b2b_pops", 64'(q_pop_res.size()), 64'd3);
        chk("b2b_mul", 64'(q_pop_res[0]), 64'h40C0_0000);
        chk("b2b_sub", 64'(q_pop_res[1]), 64'hBF80_0000);
        chk("b2b_class", 64'(q_pop_res[2]), 64'(FCLASS_NEG_INF));
        chk("b2b_gap1", 64'(q_pop_cyc[1] - q_pop_cyc[0]), 64'd1);
        chk("b2b_gap2", 64'(q_pop_cyc[2] - q_pop_cyc[1]), 64'd1);

        // Backpressure: three accepted, fourth stalls until a slot frees
        clear_log();
        cycle(1'b1, FP_ADD, ONE, ONE, 2'b00, 5'd8, 1'b0, 1'b0, acc);
        chk("bp_acc0", 64'(acc), 64'd1);
        cycle(1'b1, FP_MUL, TWO, TWO, 2'b00, 5'd9, 1'b0, 1'b0, acc);
        chk("bp_acc1", 64'(acc), 64'd1);
        cycle(1'b1, FP_SUB, TWO, ONE, 2'b00, 5'd10, 1'b0, 1'b0, acc);
        chk("bp_acc2", 64'(acc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, FP_ADD, TWO, TWO, 2'b00, 5'd11, 1'b0, 1'b0, acc);
            chk("bp_stall", 64'(acc), 64'd0);
            chk("bp_head_res", 64'(wb_result_o), 64'h4000_0000);
            chk("bp_head_rd", 64'(wb_rd_o), 64'd8);
        end
        cycle(1'b1, FP_ADD, TWO, TWO, 2'b00, 5'd11, 1'b1, 1'b0, acc);
        chk("bp_acc_on_free", 64'(acc), 64'd1);
        chk("bp_pop_same_cycle", 64'(q_pop_res.size()), 64'd1);
        idle(6, 1'b1);
        chk("bp_pops", 64'(q_pop_rd.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("bp_order", 64'(q_pop_rd[i]), 64'(8 + i));
        chk("bp_last_res", 64'(q_pop_res[3]), 64'h4080_0000);

        // WAW stall on rd7
        clear_log();
        cycle(1'b1, FP_ADD, ONE, ONE, 2'b00, 5'd7, 1'b0, 1'b0, acc);
        chk("waw_acc0", 64'(acc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, FP_MUL, TWO, TWO, 2'b00, 5'd7, 1'b0, 1'b0, acc);
            chk("waw_hold", 64'(acc), 64'd0);
        end
        cycle(1'b1, FP_MUL, TWO, TWO, 2'b00, 5'd7, 1'b1, 1'b0, acc);
        chk("waw_hold_on_pop", 64'(acc), 64'd0);
        chk("waw_popped", 64'(q_pop_rd.size()), 64'd1);
        cycle(1'b1, FP_MUL, TWO, TWO, 2'b00, 5'd7, 1'b1, 1'b0, acc);
        chk("waw_acc_after_pop", 64'(acc), 64'd1);
        idle(4, 1'b1);
        chk("waw_pops", 64'(q_pop_rd.size()), 64'd2);
        chk("waw_second_res", 64'(q_pop_res[1]), 64'h4080_0000);

        // Flush with three ops in flight and a simultaneous request
        clear_log();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, FP_ADD, ONE, ONE, 2'b00, 5'(12 + i), 1'b0, 1'b0, acc);
            chk("fl_fill", 64'(acc), 64'd1);
        end
        cycle(1'b1, FP_ADD, ONE, ONE, 2'b00, 5'd15, 1'b0, 1'b1, acc);
        chk("fl_no_accept", 64'(acc), 64'd0);
        chk("fl_busy", 64'(busy_o), 64'd0);
        chk("fl_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("fl_pend", 64'(pend_mask_o), 64'd0);
        idle(3, 1'b1);
        chk("fl_nothing_pops", 64'(q_pop_rd.size()), 64'd0);

        // Asynchronous reset with the FIFO full, then a fresh CVT
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, FP_MUL, TWO, ONE, 2'b00, 5'(1 + i), 1'b0, 1'b0, acc);
            chk("rst_fill", 64'(acc), 64'd1);
        end
        req_valid_i = 1'b0;
        chk("rst_pre_valid", 64'(wb_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_pend", 64'(pend_mask_o), 64'd0);
        chk("rst_wb_result", 64'(wb_result_o), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
        chk("rst_fpu_op", 64'(fpu_operator_o), 64'd0);
        chk("rst_fpu_a", 64'(fpu_operand_a_o), 64'd0);
        chk("rst_fpu_b", 64'(fpu_operand_b_o), 64'd0);
        chk("rst_fpu_mode", 64'(fpu_mode_o), 64'd0);
        mq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_log();
        cycle(1'b1, FP_CVT, 32'h0000_0005, 32'h0, 2'b11, 5'd1, 1'b1, 1'b0, acc);
        chk("cvt_accept", 64'(acc), 64'd1);
        idle(3, 1'b1);
        chk("cvt_pops", 64'(q_pop_res.size()), 64'd1);
        chk("cvt_result", 64'(q_pop_res[0]), 64'h40A0_0000);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, fp_alu_op_e'($urandom_range(0, 7)), $urandom(), $urandom(),
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, acc);
        end
        idle(6, 1'b1);
        chk("end_idle", 64'(busy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
